// File: rtl/msrv32_instr_fetch_buffer.sv
// Instruction fetch buffer: issues in-order fetches, queues in-order responses, presents {pc, instr} to decode.
// Redirects drop the stale responses still due from memory.
module msrv32_instr_fetch_buffer #(
   parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
   parameter int unsigned DEPTH     = 4
) (
   input  logic        ms_riscv32_mp_clk_in,
   input  logic        ms_riscv32_mp_rst_in,
   output logic [31:0] ms_riscv32_mp_imaddr_out,
   output logic        ms_riscv32_mp_imreq_out,
   input  logic        ms_riscv32_mp_instr_hready_in,
   input  logic        ms_riscv32_mp_instr_vld_in,
   input  logic [31:0] ms_riscv32_mp_instr_in,
   input  logic        branch_taken_in,
   input  logic [31:0] branch_target_in,
   input  logic        stall_in,
   output logic        instr_valid_out,
   output logic [31:0] instr_out,
   output logic [31:0] pc_out,
   output logic        flush_out
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]   pc_q;
   logic [AW-1:0] addr_wp;
   logic [AW-1:0] data_wp;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] occ_q;
   logic [CW-1:0] outst_q;
   logic [CW-1:0] drop_q;
   logic [31:0]   slot_pc    [DEPTH];
   logic [31:0]   slot_instr [DEPTH];

   logic          accept;
   logic          resp;
   logic          keep;
   logic          pop;
   logic          head_valid;
   logic [CW:0]   inflight;

   // Request gating counts dropped responses too, so every accepted fetch owns a slot until it returns.
   always_comb begin
      inflight   = (CW+1)'(occ_q) + (CW+1)'(outst_q);
      ms_riscv32_mp_imreq_out  = !ms_riscv32_mp_rst_in && !branch_taken_in &&
                                 (inflight < (CW+1)'(DEPTH));
      ms_riscv32_mp_imaddr_out = pc_q;
      accept     = ms_riscv32_mp_imreq_out && ms_riscv32_mp_instr_hready_in;
      resp       = ms_riscv32_mp_instr_vld_in && (outst_q != '0);
      keep       = resp && (drop_q == '0);
      head_valid = (occ_q != '0);
      pop        = head_valid && !stall_in && !branch_taken_in;
      instr_valid_out = head_valid;
      instr_out  = head_valid ? slot_instr[rd_ptr] : NOP;
      pc_out     = head_valid ? slot_pc[rd_ptr]    : 32'h0;
   end

   always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
      if (ms_riscv32_mp_rst_in) begin
         pc_q      <= BOOT_ADDR;
         addr_wp   <= '0;
         data_wp   <= '0;
         rd_ptr    <= '0;
         occ_q     <= '0;
         outst_q   <= '0;
         drop_q    <= '0;
         flush_out <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            slot_pc[i]    <= 32'h0;
            slot_instr[i] <= NOP;
         end
      end else if (branch_taken_in) begin
         // Everything still due from memory becomes stale; a response landing now is discarded.
         pc_q      <= branch_target_in & ~32'h3;
         addr_wp   <= '0;
         data_wp   <= '0;
         rd_ptr    <= '0;
         occ_q     <= '0;
         outst_q   <= outst_q - CW'(resp);
         drop_q    <= outst_q - CW'(resp);
         flush_out <= 1'b1;
      end else begin
         flush_out <= 1'b0;
         if (accept) begin
            slot_pc[addr_wp] <= pc_q;
            addr_wp          <= addr_wp + AW'(1);
            pc_q             <= pc_q + 32'd4;
         end
         if (resp && (drop_q != '0)) begin
            drop_q <= drop_q - CW'(1);
         end
         if (keep) begin
            slot_instr[data_wp] <= ms_riscv32_mp_instr_in;
            data_wp             <= data_wp + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         outst_q <= outst_q + CW'(accept) - CW'(resp);
         occ_q   <= occ_q + CW'(keep) - CW'(pop);
      end
   end

endmodule

// File: tb/tb_msrv32_instr_fetch_buffer.sv
// Directed bench for the fetch buffer: memory model with configurable latency plus an output scoreboard.
module tb_msrv32_instr_fetch_buffer;

   typedef struct {
      logic [31:0] addr;
      int unsigned due;
   } mreq_t;

   logic        clk;
   logic        rst;
   logic [31:0] imaddr;
   logic        imreq;
   logic        hready;
   logic        vld;
   logic [31:0] instr_in;
   logic        branch;
   logic [31:0] target;
   logic        stall;
   logic        instr_valid;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic        flush;

   int          tests;
   int          fails;
   int          acc_cnt;
   int          pop_cnt;
   int unsigned cyc;
   int unsigned lat;
   logic        resp_en;
   logic        prev_branch;
   logic [31:0] exp_pc;
   logic [63:0] exp_q [$];
   mreq_t       mem_q [$];

   msrv32_instr_fetch_buffer #(.BOOT_ADDR(32'h0000_0000), .DEPTH(4)) dut (
      .ms_riscv32_mp_clk_in          (clk),
      .ms_riscv32_mp_rst_in          (rst),
      .ms_riscv32_mp_imaddr_out      (imaddr),
      .ms_riscv32_mp_imreq_out       (imreq),
      .ms_riscv32_mp_instr_hready_in (hready),
      .ms_riscv32_mp_instr_vld_in    (vld),
      .ms_riscv32_mp_instr_in        (instr_in),
      .branch_taken_in               (branch),
      .branch_target_in              (target),
      .stall_in                      (stall),
      .instr_valid_out               (instr_valid),
      .instr_out                     (instr_out),
      .pc_out                        (pc_out),
      .flush_out                     (flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h0000_00A0 + (a >> 2);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Memory: answers accepted requests in order, one per cycle, once their latency has elapsed.
   always @(posedge clk) begin
      cyc++;
      #1;
      if (rst) begin
         vld = 1'b0;
      end else if (resp_en && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         vld      = 1'b1;
         instr_in = mem_word(mem_q[0].addr);
      end else begin
         vld = 1'b0;
      end
   end

   // Monitor: checks flush, idle outputs, pops against the scoreboard, and records accepted fetches.
   always @(negedge clk) begin
      if (rst) begin
         prev_branch = 1'b0;
      end else begin
         chk("flush_pulse", 32'(flush), 32'(prev_branch));
         if (!instr_valid) begin
            chk("idle_instr", instr_out, 32'h13);
            chk("idle_pc", pc_out, 32'h0);
         end else if (!stall && !branch) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL pop_unexpected: got pc %h instr %h expected none", pc_out, instr_out);
            end else begin
               logic [63:0] e;
               e = exp_q.pop_front();
               chk("pop_pc", pc_out, e[63:32]);
               chk("pop_instr", instr_out, e[31:0]);
               pop_cnt++;
            end
         end
         if (vld && mem_q.size() > 0) void'(mem_q.pop_front());
         if (branch) begin
            chk("imreq_in_branch", 32'(imreq), 32'h0);
            exp_q.delete();
            exp_pc = target & ~32'h3;
         end else if (imreq && hready) begin
            chk("imaddr", imaddr, exp_pc);
            exp_q.push_back({exp_pc, mem_word(exp_pc)});
            mem_q.push_back('{imaddr, cyc + lat});
            exp_pc = exp_pc + 32'd4;
            acc_cnt++;
         end
         prev_branch = branch;
      end
   end

   initial begin
      int  a0;
      int  p0;
      bit  found;
      tests = 0; fails = 0; acc_cnt = 0; pop_cnt = 0; cyc = 0;
      lat = 1; resp_en = 1'b1; prev_branch = 1'b0; exp_pc = 32'h0;
      rst = 1'b1; hready = 1'b1; stall = 1'b1; branch = 1'b0; target = 32'h0;
      vld = 1'b0; instr_in = 32'h0;

      // Reset values while reset is held
      repeat (2) tick();
      @(negedge clk);
      chk("rst_valid", 32'(instr_valid), 32'h0);
      chk("rst_instr", instr_out, 32'h13);
      chk("rst_pc", pc_out, 32'h0);
      chk("rst_imreq", 32'(imreq), 32'h0);
      chk("rst_flush", 32'(flush), 32'h0);
      tick();
      rst = 1'b0;
      a0 = acc_cnt;

      // Stalled decode: exactly DEPTH accepts, then requests stop
      repeat (10) tick();
      chk("stall_accepts", 32'(acc_cnt - a0), 32'd4);
      @(negedge clk);
      chk("stall_imreq", 32'(imreq), 32'h0);
      chk("stall_head_valid", 32'(instr_valid), 32'h1);
      chk("stall_head_pc", pc_out, 32'h0);
      chk("stall_head_instr", instr_out, 32'hA0);
      tick();
      stall = 1'b0; hready = 1'b0;
      p0 = pop_cnt;
      repeat (4) tick();
      chk("drain_pops", 32'(pop_cnt - p0), 32'd4);
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      chk("drain_valid", 32'(instr_valid), 32'h0);

      // Async reset with three entries buffered
      tick();
      stall = 1'b1; hready = 1'b1;
      repeat (3) tick();
      hready = 1'b0;
      repeat (2) tick();
      chk("pre_rst_valid", 32'(instr_valid), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", 32'(instr_valid), 32'h0);
      chk("arst_instr", instr_out, 32'h13);
      chk("arst_pc", pc_out, 32'h0);
      chk("arst_imreq", 32'(imreq), 32'h0);
      exp_q.delete();
      mem_q.delete();
      exp_pc = 32'h0;
      stall = 1'b0; hready = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("boot_imaddr", imaddr, 32'h0);
      chk("boot_imreq", 32'(imreq), 32'h1);

      // hready low holds the address
      tick();
      tick();
      hready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("hold_imaddr", imaddr, 32'h8);
         chk("hold_imreq", 32'(imreq), 32'h1);
         tick();
      end
      hready = 1'b1;

      // Sustained one fetch per cycle
      repeat (4) tick();
      repeat (8) begin
         @(negedge clk);
         chk("stream_valid", 32'(instr_valid), 32'h1);
         tick();
      end

      // Branch with two responses outstanding
      hready = 1'b0;
      repeat (3) tick();
      resp_en = 1'b0; hready = 1'b1;
      repeat (2) tick();
      hready = 1'b0; branch = 1'b1; target = 32'h0000_0103;
      tick();
      branch = 1'b0; hready = 1'b1; resp_en = 1'b1;
      @(negedge clk);
      chk("br_flush", 32'(flush), 32'h1);
      chk("br_imaddr", imaddr, 32'h100);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (instr_valid) found = 1'b1;
      end
      if (found) begin
         chk("br_first_pc", pc_out, 32'h100);
         chk("br_first_instr", instr_out, 32'hE0);
      end else begin
         tests++;
         fails++;
         $display("FAIL br_first_valid: got no valid output expected pc 00000100");
      end

      // Branch colliding with a pop and a response
      tick();
      hready = 1'b0;
      repeat (4) tick();
      hready = 1'b1;
      repeat (5) tick();
      branch = 1'b1; target = 32'h0000_0200;
      @(negedge clk);
      chk("br2_pre_valid", 32'(instr_valid), 32'h1);
      chk("br2_imreq", 32'(imreq), 32'h0);
      tick();
      branch = 1'b0;
      @(negedge clk);
      chk("br2_valid", 32'(instr_valid), 32'h0);
      chk("br2_instr", instr_out, 32'h13);
      chk("br2_pc", pc_out, 32'h0);
      chk("br2_flush", 32'(flush), 32'h1);

      // Run on, then drain everything
      tick();
      repeat (6) tick();
      hready = 1'b0;
      repeat (6) tick();
      chk("final_empty", 32'(exp_q.size()), 32'd0);
      chk("final_mem_empty", 32'(mem_q.size()), 32'd0);
      chk("final_valid", 32'(instr_valid), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
